// File: rtl/db_mem_responder_if.sv
// Data-bus request/response bundle between a bus master and an address-decoded responder.
// Signals: db_addr/db_dataIn/db_accessType/db_memLen from master, db_dataOut/db_ready/db_err back.
// Encodings: accessType 0=NONE 1=R 2=W 3=X; memLen 0=BYTE 1=HALF 2=WORD.
interface db_mem_if;
    logic [31:0] db_addr;
    logic [31:0] db_dataIn;
    logic [31:0] db_dataOut;
    logic [1:0]  db_accessType;
    logic [1:0]  db_memLen;
    logic        db_ready;
    logic        db_err;

    modport master (
        output db_addr, db_dataIn, db_accessType, db_memLen,
        input  db_dataOut, db_ready, db_err
    );

    modport slave (
        input  db_addr, db_dataIn, db_accessType, db_memLen,
        output db_dataOut, db_ready, db_err
    );
endinterface

// File: rtl/db_mem_responder.sv
// Data-bus responder serving byte/half/word R/W/X accesses from an on-chip 2^ADDR_WIDTH x 32 word RAM.
// Latency: request accepted at edge T, one-cycle db_ready pulse in cycle T+1+WAIT_CYCLES.
// Backpressure: master holds the request until db_ready; accessType==NONE during wait states aborts.
// Ports: clk, res (sync, active-high), bus (db_mem_if.slave).
// Optional feature macro DB_MEM_MISALIGN_ERR_EN: misaligned accesses report db_err instead of
// silently masking the low address bits.
module db_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       res,
    db_mem_if.slave    bus
);
    localparam logic [1:0] ACC_NONE = 2'd0;
    localparam logic [1:0] ACC_W    = 2'd2;
    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam int         CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

    state_t                  state;
    logic [CW-1:0]           wait_cnt;
    logic [ADDR_WIDTH-1:0]   lat_word;
    logic [1:0]              lat_lane;
    logic [1:0]              lat_len;
    logic                    lat_write;
    logic                    lat_err;
    logic [31:0]             lat_data;

    // Decode of the request currently on the bus.
    logic                    sel;
    logic                    accept;
    logic [ADDR_WIDTH-1:0]   cur_word;
    logic [1:0]              cur_lane;
    logic                    cur_write;
    logic                    cur_err;

    assign sel       = (bus.db_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign accept    = (state == IDLE) && (bus.db_accessType != ACC_NONE) && sel;
    assign cur_word  = bus.db_addr[ADDR_WIDTH+1:2];
    assign cur_write = (bus.db_accessType == ACC_W);

`ifdef DB_MEM_MISALIGN_ERR_EN
    assign cur_lane = bus.db_addr[1:0];
    assign cur_err  = ((bus.db_memLen == LEN_HALF) && bus.db_addr[0]) ||
                      ((bus.db_memLen != LEN_BYTE) && (bus.db_memLen != LEN_HALF) &&
                       (bus.db_addr[1:0] != 2'b00));
`else
    // Misaligned accesses are forced onto their natural boundary.
    always_comb begin
        cur_lane = bus.db_addr[1:0];
        if (bus.db_memLen == LEN_HALF)
            cur_lane = {bus.db_addr[1], 1'b0};
        else if (bus.db_memLen != LEN_BYTE)
            cur_lane = 2'b00;
    end
    assign cur_err = 1'b0;
`endif

    // Response source: with zero wait states the response is formed on the accept edge,
    // before the latched copy exists, so the live bus request is used from IDLE.
    logic                    from_bus;
    logic [ADDR_WIDTH-1:0]   src_word;
    logic [1:0]              src_lane;
    logic [1:0]              src_len;
    logic                    src_write;
    logic                    src_err;
    logic [31:0]             rd_word;
    logic [31:0]             rd_sh;
    logic [31:0]             resp_data;

    assign from_bus  = (state == IDLE);
    assign src_word  = from_bus ? cur_word          : lat_word;
    assign src_lane  = from_bus ? cur_lane          : lat_lane;
    assign src_len   = from_bus ? bus.db_memLen     : lat_len;
    assign src_write = from_bus ? cur_write         : lat_write;
    assign src_err   = from_bus ? cur_err           : lat_err;
    assign rd_word   = mem[src_word];

    always_comb begin
        rd_sh     = rd_word >> {src_lane, 3'b000};
        resp_data = 32'h0;
        if (!src_write && !src_err) begin
            case (src_len)
                LEN_BYTE: resp_data = {24'h0, rd_sh[7:0]};
                LEN_HALF: resp_data = {16'h0, rd_sh[15:0]};
                default:  resp_data = rd_word;
            endcase
        end
    end

    // Byte-enable merge for the write that commits on the RESP edge.
    logic [31:0] wr_old;
    logic [31:0] wr_word;

    assign wr_old = mem[lat_word];

    always_comb begin
        wr_word = wr_old;
        case (lat_len)
            LEN_BYTE: wr_word[{lat_lane, 3'b000} +: 8]      = lat_data[7:0];
            LEN_HALF: wr_word[{lat_lane[1], 4'b0000} +: 16] = lat_data[15:0];
            default:  wr_word = lat_data;
        endcase
    end

    // RAM is never cleared; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!res && (state == RESP) && lat_write && !lat_err)
            mem[lat_word] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            lat_word       <= '0;
            lat_lane       <= 2'b00;
            lat_len        <= LEN_BYTE;
            lat_write      <= 1'b0;
            lat_err        <= 1'b0;
            lat_data       <= 32'h0;
            bus.db_ready   <= 1'b0;
            bus.db_dataOut <= 32'h0;
            bus.db_err     <= 1'b0;
        end else begin
            bus.db_ready <= 1'b0;
            bus.db_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_word  <= cur_word;
                        lat_lane  <= cur_lane;
                        lat_len   <= bus.db_memLen;
                        lat_write <= cur_write;
                        lat_err   <= cur_err;
                        lat_data  <= bus.db_dataIn;
                        wait_cnt  <= CW'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            state          <= RESP;
                            bus.db_ready   <= 1'b1;
                            bus.db_dataOut <= resp_data;
                            bus.db_err     <= src_err;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.db_accessType == ACC_NONE) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                        if (wait_cnt == CW'(1)) begin
                            state          <= RESP;
                            bus.db_ready   <= 1'b1;
                            bus.db_dataOut <= resp_data;
                            bus.db_err     <= src_err;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_db_mem_responder.sv
// Bench for db_mem_responder: three instances (0, 1 and 3 wait states, one with a non-zero base)
// driven with directed and random accesses, checked against a byte-addressed memory model.
module tb_db_mem_responder;
    localparam logic [1:0] NONE = 2'd0, RD = 2'd1, WR = 2'd2, EX = 2'd3;
    localparam logic [1:0] BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2;
    localparam int          WT[3]   = '{0, 1, 3};
    localparam logic [31:0] BASE[3] = '{32'h0, 32'h0, 32'h8000_0000};

    logic clk = 1'b0;
    logic res = 1'b1;
    always #5 clk = ~clk;

    db_mem_if bus0 ();
    db_mem_if bus1 ();
    db_mem_if bus2 ();

    logic [31:0] adr[3];
    logic [31:0] din[3];
    logic [1:0]  acc[3];
    logic [1:0]  len[3];
    logic        rdy[3];
    logic        err[3];
    logic [31:0] dout[3];

    assign bus0.db_addr = adr[0]; assign bus0.db_dataIn = din[0];
    assign bus0.db_accessType = acc[0]; assign bus0.db_memLen = len[0];
    assign bus1.db_addr = adr[1]; assign bus1.db_dataIn = din[1];
    assign bus1.db_accessType = acc[1]; assign bus1.db_memLen = len[1];
    assign bus2.db_addr = adr[2]; assign bus2.db_dataIn = din[2];
    assign bus2.db_accessType = acc[2]; assign bus2.db_memLen = len[2];
    assign rdy[0] = bus0.db_ready; assign err[0] = bus0.db_err; assign dout[0] = bus0.db_dataOut;
    assign rdy[1] = bus1.db_ready; assign err[1] = bus1.db_err; assign dout[1] = bus1.db_dataOut;
    assign rdy[2] = bus2.db_ready; assign err[2] = bus2.db_err; assign dout[2] = bus2.db_dataOut;

    db_mem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0), .BASE_ADDR(32'h0))
        u0 (.clk(clk), .res(res), .bus(bus0));
    db_mem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(1), .BASE_ADDR(32'h0))
        u1 (.clk(clk), .res(res), .bus(bus1));
    db_mem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(3), .BASE_ADDR(32'h8000_0000))
        u2 (.clk(clk), .res(res), .bus(bus2));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference memory: first 64 bytes of each instance's window, little-endian bytes.
    logic [7:0] mb [3][64];

    task automatic model(input int i, input logic [1:0] t, input logic [1:0] ln, input int off,
                         input logic [31:0] d, output logic [31:0] ed, output logic ee);
        int n = 1 << ln;
        int a = off;
        ed = 32'h0;
        ee = 1'b0;
        if (a % n != 0) begin
`ifdef DB_MEM_MISALIGN_ERR_EN
            ee = 1'b1;
            return;
`else
            a = a - (a % n);
`endif
        end
        for (int k = 0; k < n; k++) begin
            if (t == WR) mb[i][a + k] = d[8*k +: 8];
            else         ed[8*k +: 8] = mb[i][a + k];
        end
    endtask

    // Full request/response exchange; bus fields are scrambled while waiting to show
    // the responder uses its latched copy.
    task automatic txn(input int i, input logic [1:0] t, input logic [1:0] ln, input int off,
                       input logic [31:0] d, output logic [31:0] got);
        logic [31:0] ed;
        logic        ee;
        int          lat = 0;
        bit          seen = 0;
        model(i, t, ln, off, d, ed, ee);
        @(negedge clk);
        acc[i] = t; adr[i] = BASE[i] + off; din[i] = d; len[i] = ln;
        @(posedge clk);
        while (!seen && lat < 12) begin
            @(negedge clk);
            lat++;
            if (rdy[i]) seen = 1;
            else begin
                adr[i] = $urandom; din[i] = $urandom; len[i] = 2'($urandom_range(0, 2));
            end
        end
        chk("latency", lat, WT[i] + 1);
        got = dout[i];
        chk("data", dout[i], ed);
        chk("err", {31'h0, err[i]}, {31'h0, ee});
        acc[i] = NONE;
        @(negedge clk);
        chk("pulse_width", {31'h0, rdy[i]}, 32'h0);
        chk("data_hold", dout[i], ed);
        chk("err_idle", {31'h0, err[i]}, 32'h0);
    endtask

    task automatic watch(input int i, input int n, input string tag);
        int hits = 0;
        repeat (n) begin
            @(negedge clk);
            if (rdy[i]) hits++;
        end
        chk(tag, hits, 0);
    endtask

    initial begin
        logic [31:0] g;
        for (int i = 0; i < 3; i++) begin
            adr[i] = 32'h0; din[i] = 32'h0; acc[i] = NONE; len[i] = WORD;
        end
        repeat (3) @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", {31'h0, rdy[i]}, 32'h0);
            chk("rst_data", dout[i], 32'h0);
            chk("rst_err", {31'h0, err[i]}, 32'h0);
        end

        // Preload the modelled window of every instance.
        for (int i = 0; i < 3; i++)
            for (int w = 0; w < 16; w++) txn(i, WR, WORD, w * 4, $urandom, g);

        // Word write/read, then byte write with narrow reads.
        txn(1, WR, WORD, 'h10, 32'hDEAD_BEEF, g);
        txn(1, RD, WORD, 'h10, 32'h0, g);   chk("t1_word", g, 32'hDEAD_BEEF);
        txn(1, WR, BYTE, 'h13, 32'h0000_00AA, g);
        txn(1, RD, WORD, 'h10, 32'h0, g);   chk("t2_word", g, 32'hAAAD_BEEF);
        txn(1, EX, HALF, 'h12, 32'h0, g);   chk("t2_half", g, 32'h0000_AAAD);
        txn(1, RD, BYTE, 'h11, 32'h0, g);   chk("t2_byte", g, 32'h0000_00BE);

        // Abort during wait states of a 3-wait-state write.
        @(negedge clk);
        acc[2] = WR; adr[2] = BASE[2] + 'h20; din[2] = 32'h1; len[2] = WORD;
        @(posedge clk);
        repeat (2) @(negedge clk);
        acc[2] = NONE;
        watch(2, 10, "abort_no_ready");
        txn(2, RD, WORD, 'h20, 32'h0, g);

        // Requests outside the decode window.
        @(negedge clk);
        acc[1] = RD; adr[1] = 32'h0000_4000; len[1] = WORD;
        acc[2] = RD; adr[2] = 32'h0000_0010; len[2] = WORD;
        watch(1, 10, "undecoded_u1");
        watch(2, 1, "undecoded_u2");
        acc[1] = NONE; acc[2] = NONE;

        // Misaligned word write.
        txn(1, WR, WORD, 'h11, 32'h1234_5678, g);
        txn(1, RD, WORD, 'h10, 32'h0, g);
`ifdef DB_MEM_MISALIGN_ERR_EN
        chk("misalign_word", g, 32'hAAAD_BEEF);
`else
        chk("misalign_word", g, 32'h1234_5678);
`endif

        // Reset during wait states.
        @(negedge clk);
        acc[2] = WR; adr[2] = BASE[2] + 'h30; din[2] = 32'hCAFE_F00D; len[2] = WORD;
        @(posedge clk);
        @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {31'h0, rdy[2]}, 32'h0);
        chk("midrst_data", dout[2], 32'h0);
        chk("midrst_err", {31'h0, err[2]}, 32'h0);
        acc[2] = NONE;
        res = 1'b0;
        watch(2, 10, "midrst_no_ready");
        txn(2, RD, WORD, 'h30, 32'h0, g);
        txn(0, WR, HALF, 'h06, 32'h0000_5A5A, g);
        txn(0, RD, HALF, 'h06, 32'h0, g);   chk("wait0_half", g, 32'h0000_5A5A);

        // Random traffic across all instances.
        for (int n = 0; n < 300; n++) begin
            int i = $urandom_range(0, 2);
            txn(i, 2'($urandom_range(1, 3)), 2'($urandom_range(0, 2)),
                $urandom_range(0, 63), $urandom, g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
